dif_lut_prog_k10w12: RTL and testbench
======================================

DIF_LUT_PROG_K10W12 -- requirements
Module: dif_lut_prog_k10w12

Interface
REQ-001 The block SHALL have parameter KEY_BIT, default 10, meaning key width (signed).
REQ-002 The block SHALL have parameter WORD_BIT, default 12, meaning value width (signed).
REQ-003 The block SHALL have parameter NSEG, default 20, meaning segment count: NSEG-1 boundaries plus NSEG values.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-006 The block SHALL have port cfg_valid, input, 1, table-load entry offered.
REQ-007 The block SHALL have port cfg_ready, output, 1, load entry accepted when high together with cfg_valid.
REQ-008 The block SHALL have port cfg_bound, input, KEY_BIT, signed segment upper boundary; ignored on the final entry.
REQ-009 The block SHALL have port cfg_value, input, WORD_BIT, segment value.
REQ-010 The block SHALL have port cfg_last, input, 1, marks the final (NSEG-th) entry.
REQ-011 The block SHALL have port tbl_ready, output, 1, table complete and valid.
REQ-012 The block SHALL have port cfg_err, output, 1, sticky load-error flag.
REQ-013 The block SHALL have port lk_valid, input, 1, lookup request.
REQ-014 The block SHALL have port lk_key, input, KEY_BIT, signed lookup key.
REQ-015 The block SHALL have port out_valid, output, 1, lookup result valid.
REQ-016 The block SHALL have port out_value, output, WORD_BIT, signed lookup result.

Function
REQ-017 The block SHALL implement states EMPTY, LOAD, READY and ERR.
- EMPTY→LOAD on the first cfg_valid.
- LOAD→READY when cfg_last is accepted as entry NSEG-1.
- Any state→ERR on a load violation.
- READY or ERR→LOAD on a new cfg_valid, which restarts at entry 0 and clears cfg_err and tbl_ready.
REQ-018 cfg_ready SHALL be 1 in EMPTY, LOAD, READY and ERR, so every entry is accepted in the cycle it is offered.
REQ-019 An entry counter SHALL increment per accepted entry, and entry i SHALL write bound[i] and val[i].
REQ-020 The following load violations SHALL set cfg_err:
- cfg_last on an entry other than NSEG-1;
- entry NSEG-1 without cfg_last;
- cfg_bound[i] <= cfg_bound[i-1], signed, for 0<i<NSEG-1.
REQ-021 In ERR, entries SHALL be accepted and discarded until a restart.
REQ-022 tbl_ready SHALL be 1 only in READY.
REQ-023 A lookup result SHALL be val[i] for the smallest i with lk_key < bound[i] (signed compare), else val[NSEG-1].
REQ-024 The lookup SHALL be a 2-stage pipeline:
- stage 1 registers the NSEG-1 comparator vector and a valid bit;
- stage 2 priority-encodes and registers out_value.
- Latency is exactly 2 cycles, with throughput 1 per cycle.
REQ-025 lk_valid SHALL be accepted only while tbl_ready=1; otherwise it is dropped and yields no out_valid.
REQ-026 Lookups already in flight when a reload starts SHALL complete using the table contents present at stage 2.
REQ-027 Table writes and stage-1 compares in the same cycle SHALL see the pre-write contents.
REQ-028 The comparison SHALL handle key=-2^(KEY_BIT-1) and key=2^(KEY_BIT-1)-1 without overflow.

Reset
REQ-029 When rst_n=0 at a clock edge, the block SHALL set state=EMPTY, entry counter=0, tbl_ready=0, cfg_err=0, out_valid=0, out_value=0 and pipeline valids=0.
REQ-030 Reset SHALL leave table storage unchanged, because it is unreadable until tbl_ready.
REQ-031 Reset during LOAD SHALL abandon the partial table.

Structure
REQ-032 The package dif_lut_pkg SHALL hold the KEY_BIT, WORD_BIT and NSEG defaults and the state enum.
REQ-033 One sub-module, dif_lut_penc, SHALL perform the combinational priority encode from comparator vector to segment index.

Verification
REQ-034 The bench SHALL load the table with bounds 48,68,83,96,107,117,127,136,145,155,166,178,191,206,224,246,277,352,511 and values 0x60F,0x5FD,...,0x63E,0x64E, and check:
- key 47 → 0x60F;
- key 48 → 0x5FD;
- key 511 → 0x64E;
- key -512 → 0x60F;
- each result arrives exactly 2 cycles after lk_valid.
REQ-035 The bench SHALL drive back-to-back lookups of keys 0,100,300,510 on consecutive cycles and check that 4 consecutive out_valid carry matching values.
REQ-036 The bench SHALL load with bound[3]=bound[2] and check cfg_err=1, tbl_ready=0, and no out_valid for subsequent lookups.
REQ-037 The bench SHALL assert cfg_last on entry 5 and check cfg_err=1, then perform a full valid reload and check cfg_err=0 and tbl_ready=1.
REQ-038 The bench SHALL assert rst_n=0 for 1 cycle after entry 10 of a load and check that all outputs are 0 next cycle and that lookups are dropped until a new full load.
REQ-039 The bench SHALL issue a lookup one cycle before a reload starts and check that it still returns the old-table value.

Source files
------------

// File: rtl/dif_lut_pkg.sv
// Shared defaults and FSM state encoding for the programmable segment lookup table.
package dif_lut_pkg;

    localparam int LUT_KEY_BIT  = 10;
    localparam int LUT_WORD_BIT = 12;
    localparam int LUT_NSEG     = 20;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2,
        ST_ERR   = 2'd3
    } lut_state_t;

endpackage

// File: rtl/dif_lut_penc.sv
// Priority encoder: lowest set bit of the key<bound vector selects the segment,
// no bit set selects the final (open-ended) segment.
module dif_lut_penc
    import dif_lut_pkg::*;
#(
    parameter int NSEG  = LUT_NSEG,
    parameter int IDX_W = $clog2(NSEG)
) (
    input  logic [NSEG-2:0]  lt,
    output logic [IDX_W-1:0] seg
);

    always_comb begin
        seg = IDX_W'(NSEG - 1);
        for (int i = NSEG - 2; i >= 0; i--) begin
            if (lt[i]) seg = IDX_W'(i);
        end
    end

endmodule

// File: rtl/dif_lut_prog_k10w12.sv
// Programmable piecewise-constant lookup: signed key mapped to a signed value by
// ascending segment boundaries, loaded entry-by-entry, looked up in two stages.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_EMPTY | no table since reset; first cfg_valid starts a load
// ST_LOAD  | entries 1..NSEG-1 being accepted in order
// ST_READY | table complete; lookups accepted
// ST_ERR   | load violated; entries discarded until the burst's cfg_last
module dif_lut_prog_k10w12
    import dif_lut_pkg::*;
#(
    parameter int KEY_BIT  = LUT_KEY_BIT,
    parameter int WORD_BIT = LUT_WORD_BIT,
    parameter int NSEG     = LUT_NSEG
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [KEY_BIT-1:0]  cfg_bound,
    input  logic [WORD_BIT-1:0] cfg_value,
    input  logic                cfg_last,
    output logic                tbl_ready,
    output logic                cfg_err,
    input  logic                lk_valid,
    input  logic [KEY_BIT-1:0]  lk_key,
    output logic                out_valid,
    output logic [WORD_BIT-1:0] out_value
);

    localparam int IDX_W = $clog2(NSEG);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSEG - 1);

    lut_state_t state, state_nxt;
    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic drain_open;
    logic restart;
    logic load_acc;
    logic is_final;
    logic viol;
    logic signed [KEY_BIT-1:0] prev_bound;

    logic signed [KEY_BIT-1:0]  bound [NSEG-1];
    logic signed [WORD_BIT-1:0] val   [NSEG];

    logic [NSEG-2:0]  lt_d;
    logic [NSEG-2:0]  s1_lt;
    logic             s1_valid;
    logic [IDX_W-1:0] seg;

    // A new entry restarts at 0 unless we are mid-load or still draining a bad burst.
    always_comb begin
        restart    = cfg_valid && (state != ST_LOAD) && !(state == ST_ERR && drain_open);
        load_acc   = cfg_valid && ((state == ST_LOAD) || restart);
        idx        = restart ? '0 : cnt;
        is_final   = (idx == LAST_IDX);
        prev_bound = (idx != '0 && !is_final) ? bound[idx - 1'b1] : '0;
        viol       = load_acc && ((cfg_last != is_final) ||
                     (idx != '0 && !is_final && $signed(cfg_bound) <= prev_bound));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (viol)          state_nxt = ST_ERR;
        else if (load_acc) state_nxt = is_final ? ST_READY : ST_LOAD;
    end

    always_comb begin
        cfg_ready = 1'b1;
        tbl_ready = (state == ST_READY);
        cfg_err   = (state == ST_ERR);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            drain_open <= 1'b0;
        end else begin
            if (load_acc) cnt <= is_final ? '0 : idx + 1'b1;
            if (viol)
                drain_open <= !cfg_last;
            else if (state == ST_ERR && drain_open && cfg_valid && cfg_last)
                drain_open <= 1'b0;
        end
    end

    // Table storage carries no reset; it is unreadable until tbl_ready anyway.
    always_ff @(posedge clk) begin
        if (rst_n && load_acc) begin
            if (!is_final) bound[idx] <= $signed(cfg_bound);
            val[idx] <= $signed(cfg_value);
        end
    end

    always_comb begin
        lt_d = '0;
        for (int i = 0; i < NSEG - 1; i++) begin
            lt_d[i] = ($signed(lk_key) < bound[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) s1_valid <= 1'b0;
        else        s1_valid <= lk_valid && tbl_ready;
    end

    always_ff @(posedge clk) begin
        s1_lt <= lt_d;
    end

    dif_lut_penc #(.NSEG(NSEG)) u_penc (
        .lt  (s1_lt),
        .seg (seg)
    );

    // Stage 2 reads val[] before any same-edge write, so in-flight lookups see the old table.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_value <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) out_value <= val[seg];
        end
    end

endmodule

// File: tb/tb_dif_lut_prog_k10w12.sv
// Directed bench for the programmable segment lookup: loads, lookups, latency,
// load errors, reset mid-load and lookups straddling a reload.
module tb_dif_lut_prog_k10w12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [9:0]  cfg_bound;
    logic [11:0] cfg_value;
    logic        cfg_last;
    logic        tbl_ready;
    logic        cfg_err;
    logic        lk_valid;
    logic [9:0]  lk_key;
    logic        out_valid;
    logic [11:0] out_value;

    int n_vec  = 0;
    int n_miss = 0;

    int bnd [19] = '{48, 68, 83, 96, 107, 117, 127, 136, 145, 155,
                     166, 178, 191, 206, 224, 246, 277, 352, 511};
    int vtab [20] = '{'h60F, 'h5FD, 'h5F0, 'h5E8, 'h5E4, 'h5E3, 'h5E5, 'h5EA, 'h5F1, 'h5FA,
                      'h604, 'h60F, 'h61A, 'h624, 'h62D, 'h634, 'h639, 'h63C, 'h63E, 'h64E};

    dif_lut_prog_k10w12 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_bound (cfg_bound),
        .cfg_value (cfg_value),
        .cfg_last  (cfg_last),
        .tbl_ready (tbl_ready),
        .cfg_err   (cfg_err),
        .lk_valid  (lk_valid),
        .lk_key    (lk_key),
        .out_valid (out_valid),
        .out_value (out_value)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_entry(input int i, input int last_at, input int dup_at, input int voff);
        cfg_valid = 1'b1;
        if (i == dup_at)  cfg_bound = 10'(bnd[i-1]);
        else if (i < 19)  cfg_bound = 10'(bnd[i]);
        else              cfg_bound = 10'd0;
        cfg_value = 12'(vtab[i] + voff);
        cfg_last  = (i == last_at);
    endtask

    task automatic load(input int first, input int n, input int last_at,
                        input int dup_at, input int voff);
        for (int i = first; i < n; i++) begin
            drive_entry(i, last_at, dup_at, voff);
            tick;
        end
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic lookup(input string tag, input int key, input int exp);
        lk_valid = 1'b1;
        lk_key   = 10'(key);
        tick;
        lk_valid = 1'b0;
        chk({tag, "_early"}, 32'(out_valid), 0);
        tick;
        chk({tag, "_valid"}, 32'(out_valid), 1);
        chk({tag, "_value"}, 32'(out_value), 32'(exp));
    endtask

    task automatic dropped(input string tag, input int key);
        lk_valid = 1'b1;
        lk_key   = 10'(key);
        tick;
        lk_valid = 1'b0;
        chk({tag, "_c1"}, 32'(out_valid), 0);
        tick;
        chk({tag, "_c2"}, 32'(out_valid), 0);
    endtask

    int bb_key [4] = '{0, 100, 300, 510};
    int bb_exp [4] = '{'h60F, 'h5E4, 'h63C, 'h63E};

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_bound = '0; cfg_value = '0;
        cfg_last = 1'b0; lk_valid = 1'b0; lk_key = '0;
        tick; tick;
        chk("rst_tbl_ready", 32'(tbl_ready), 0);
        chk("rst_cfg_err",   32'(cfg_err), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_value", 32'(out_value), 0);
        chk("rst_cfg_ready", 32'(cfg_ready), 1);
        rst_n = 1'b1;
        tick;
        dropped("empty_drop", 47);

        load(0, 20, 19, -1, 0);
        chk("load_tbl_ready", 32'(tbl_ready), 1);
        chk("load_cfg_err",   32'(cfg_err), 0);
        lookup("k47",   47, 'h60F);
        lookup("k48",   48, 'h5FD);
        lookup("k511", 511, 'h64E);
        lookup("kmin", -512, 'h60F);

        // Back-to-back: the result for key k appears after the edge that samples key k+1.
        for (int k = 0; k < 6; k++) begin
            lk_valid = (k < 4);
            lk_key   = (k < 4) ? 10'(bb_key[k]) : 10'd0;
            tick;
            if (k == 0) chk("bb_none", 32'(out_valid), 0);
            else if (k <= 4) begin
                chk($sformatf("bb%0d_valid", k - 1), 32'(out_valid), 1);
                chk($sformatf("bb%0d_value", k - 1), 32'(out_value), 32'(bb_exp[k-1]));
            end else chk("bb_tail", 32'(out_valid), 0);
        end
        lk_valid = 1'b0;

        // Lookup one cycle before a reload with shifted values must return the old value.
        lk_valid = 1'b1;
        lk_key   = 10'd0;
        tick;
        lk_valid = 1'b0;
        drive_entry(0, 19, -1, 1);
        tick;
        chk("straddle_valid", 32'(out_valid), 1);
        chk("straddle_value", 32'(out_value), 'h60F);
        chk("straddle_tbl",   32'(tbl_ready), 0);
        load(1, 20, 19, -1, 1);
        chk("reload_ready", 32'(tbl_ready), 1);
        lookup("new_k47", 47, 'h610);

        load(0, 20, 19, 3, 0);
        chk("dup_cfg_err",   32'(cfg_err), 1);
        chk("dup_tbl_ready", 32'(tbl_ready), 0);
        dropped("dup_drop", 47);

        load(0, 6, 5, -1, 0);
        chk("early_last_err", 32'(cfg_err), 1);
        load(0, 20, 19, -1, 0);
        chk("recover_err",   32'(cfg_err), 0);
        chk("recover_ready", 32'(tbl_ready), 1);
        lookup("recover_k48", 48, 'h5FD);

        load(0, 11, -1, -1, 0);
        chk("partial_ready", 32'(tbl_ready), 0);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        chk("midrst_tbl_ready", 32'(tbl_ready), 0);
        chk("midrst_cfg_err",   32'(cfg_err), 0);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_out_value", 32'(out_value), 0);
        dropped("midrst_drop", 100);
        load(0, 20, 19, -1, 0);
        chk("post_rst_ready", 32'(tbl_ready), 1);
        lookup("post_rst_k100", 100, 'h5E4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
